sar_adc_ctrl_param: RTL and testbench

Parametrised successive-approximation ADC controller, successor to the fixed 12/14-bit SAR FSM. Supports a generic maximum resolution, runtime-selectable active bits, optional oversampling accumulation, a four-phase comparator handshake with timeout, and a synchronous system clock. It sits between the conversion sequencer (`st_conv`) and the capacitive DAC plus comparator macro.

---
 rtl/sar_adc_ctrl_param_if.sv | 36 +++
 rtl/sar_adc_ctrl_param.sv | 177 +++++++++++++++++
 tb/tb_sar_adc_ctrl_param.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sar_adc_ctrl_param_if.sv
// Signal bundle between the conversion sequencer / comparator macro and the SAR controller.
// Handshakes: st_conv is a level request sampled only while the controller is idle.
// comp_req/comp_ack is four-phase: req rises, the macro raises ack with comp_in valid,
// req falls, then ack falls. adc_done is a one-cycle strobe qualifying result.
interface sar_adc_ctrl_param_if #(
  parameter int N            = 14,
  parameter int OSR_MAX_LOG2 = 4
);
  localparam int NBW = $clog2(N + 1);
  localparam int OW  = (OSR_MAX_LOG2 > 0) ? $clog2(OSR_MAX_LOG2 + 1) : 1;
  localparam int RW  = N + OSR_MAX_LOG2;

  logic           st_conv;
  logic [NBW-1:0] nbits;
  logic [OW-1:0]  osr_log2;
  logic           comp_ack;
  logic           comp_in;
  logic           comp_req;
  logic           sample;
  logic [N-1:0]   dac_value;
  logic [RW-1:0]  result;
  logic           adc_done;
  logic           busy;
  logic           timeout_err;
  logic [2:0]     dbg_state;

  modport master (
    input  st_conv, nbits, osr_log2, comp_ack, comp_in,
    output comp_req, sample, dac_value, result, adc_done, busy, timeout_err, dbg_state
  );

  modport slave (
    output st_conv, nbits, osr_log2, comp_ack, comp_in,
    input  comp_req, sample, dac_value, result, adc_done, busy, timeout_err, dbg_state
  );
endinterface

// File: rtl/sar_adc_ctrl_param.sv
// Parametrised SAR ADC controller: runtime resolution, oversampling accumulation,
// four-phase comparator handshake with timeout. All outputs are registered.
module sar_adc_ctrl_param #(
  parameter int N            = 14,
  parameter int OSR_MAX_LOG2 = 4,
  parameter int SAMPLE_CYC   = 2,
  parameter int TIMEOUT      = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  sar_adc_ctrl_param_if.master        bus
);
  localparam int NBW  = $clog2(N + 1);
  localparam int OW   = (OSR_MAX_LOG2 > 0) ? $clog2(OSR_MAX_LOG2 + 1) : 1;
  localparam int RW   = N + OSR_MAX_LOG2;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int CW   = OSR_MAX_LOG2 + 1;
  localparam int TMAX = (TIMEOUT > SAMPLE_CYC) ? TIMEOUT : SAMPLE_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_SET    = 3'd2,
    S_REQ    = 3'd3,
    S_REL    = 3'd4,
    S_ACCUM  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t         r_state;
  logic [IW-1:0]  r_idx;
  logic [IW-1:0]  r_lsb_idx;
  logic [CW-1:0]  r_target;
  logic [CW-1:0]  r_cnt;
  logic [TW-1:0]  r_tmr;
  logic [RW-1:0]  r_acc;
  logic [RW-1:0]  r_result;
  logic [N-1:0]   r_dac;
  logic           r_comp_req;
  logic           r_sample;
  logic           r_done;
  logic           r_busy;
  logic           r_terr;

  logic [NBW-1:0] w_nbits_eff;
  logic [OW-1:0]  w_osr_eff;
  logic [IW-1:0]  w_lsb_idx;
  logic [RW-1:0]  w_acc_next;
  logic [CW-1:0]  w_cnt_next;

  // Out-of-range settings collapse to the maximum rather than being rejected.
  always_comb begin
    w_nbits_eff = bus.nbits;
    if (bus.nbits == '0 || bus.nbits > NBW'(N)) w_nbits_eff = NBW'(N);
    w_osr_eff = bus.osr_log2;
    if (bus.osr_log2 > OW'(OSR_MAX_LOG2)) w_osr_eff = OW'(OSR_MAX_LOG2);
    w_lsb_idx  = IW'(NBW'(N) - w_nbits_eff);
    w_acc_next = r_acc + RW'(r_dac);
    w_cnt_next = r_cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_lsb_idx  <= '0;
      r_target   <= '0;
      r_cnt      <= '0;
      r_tmr      <= '0;
      r_acc      <= '0;
      r_result   <= '0;
      r_dac      <= '0;
      r_comp_req <= 1'b0;
      r_sample   <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_terr     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.st_conv) begin
            r_lsb_idx <= w_lsb_idx;
            r_target  <= CW'(1) << w_osr_eff;
            r_terr    <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_dac     <= '0;
            r_idx     <= IW'(N - 1);
            r_tmr     <= '0;
            r_sample  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (r_tmr == TW'(SAMPLE_CYC - 1)) begin
            r_sample <= 1'b0;
            r_tmr    <= '0;
            r_state  <= S_SET;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_SET: begin
          r_dac[r_idx] <= 1'b1;
          r_comp_req   <= 1'b1;
          r_tmr        <= '0;
          r_state      <= S_REQ;
        end
        S_REQ: begin
          if (bus.comp_ack) begin
            if (!bus.comp_in) r_dac[r_idx] <= 1'b0;
            r_comp_req <= 1'b0;
            r_tmr      <= '0;
            r_state    <= S_REL;
          end else if (r_tmr == TW'(TIMEOUT)) begin
            r_terr     <= 1'b1;
            r_comp_req <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_REL: begin
          if (!bus.comp_ack) begin
            r_tmr <= '0;
            if (r_idx == r_lsb_idx) begin
              r_state <= S_ACCUM;
            end else begin
              r_idx   <= r_idx - IW'(1);
              r_state <= S_SET;
            end
          end else if (r_tmr == TW'(TIMEOUT)) begin
            r_terr  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_ACCUM: begin
          r_acc <= w_acc_next;
          r_cnt <= w_cnt_next;
          // The final sum is published on the way into DONE so result and adc_done align.
          if (w_cnt_next == r_target) begin
            r_result <= w_acc_next;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_dac    <= '0;
            r_idx    <= IW'(N - 1);
            r_tmr    <= '0;
            r_sample <= 1'b1;
            r_state  <= S_SAMPLE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.comp_req    = r_comp_req;
  assign bus.sample      = r_sample;
  assign bus.dac_value   = r_dac;
  assign bus.result      = r_result;
  assign bus.adc_done    = r_done;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_terr;
  assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_sar_adc_ctrl_param.sv
// Directed bench for sar_adc_ctrl_param: ideal comparator model with programmable
// ack/release delays, result scoreboard fed at start and drained on adc_done.
module tb_sar_adc_ctrl_param;
  logic clk;
  logic rst;

  sar_adc_ctrl_param_if #(.N(14), .OSR_MAX_LOG2(4)) bus ();

  sar_adc_ctrl_param #(
    .N(14), .OSR_MAX_LOG2(4), .SAMPLE_CYC(2), .TIMEOUT(15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // comparator model
  logic [13:0] cmp_ref   = '0;
  int          ack_dly   = 1;
  int          rel_dly   = 1;
  bit          cmp_never = 1'b0;

  initial begin
    int req_cnt;
    int rel_cnt;
    req_cnt = 0;
    rel_cnt = 0;
    bus.comp_ack = 1'b0;
    bus.comp_in  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.comp_req) begin
        req_cnt++;
        rel_cnt = 0;
        if (!cmp_never && !bus.comp_ack && req_cnt >= ack_dly) begin
          bus.comp_ack = 1'b1;
          bus.comp_in  = (cmp_ref >= bus.dac_value);
        end
      end else begin
        req_cnt = 0;
        if (bus.comp_ack) begin
          rel_cnt++;
          if (rel_cnt >= rel_dly) begin
            bus.comp_ack = 1'b0;
            rel_cnt = 0;
          end
        end
      end
    end
  end

  // monitor / scoreboard
  int req_rises = 0, smp_rises = 0, done_cnt = 0, req_hi = 0, dac_low_hits = 0;
  logic prev_req = 1'b0, prev_smp = 1'b0;

  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (bus.comp_req && !prev_req) req_rises++;
      if (bus.sample && !prev_smp) smp_rises++;
      if (bus.comp_req) req_hi++;
      if (bus.dac_value[1:0] != 2'b00) dac_low_hits++;
      prev_req = bus.comp_req;
      prev_smp = bus.sample;
      if (bus.adc_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: result 0x%0h with no expected entry", bus.result);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", 32'(bus.result), 32'(e));
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Returns at the negedge of the first cycle after leaving IDLE; then scrambles
  // nbits/osr_log2 so that only the captured values can produce the right answer.
  task automatic start_conv(input logic [3:0] nb, input logic [2:0] osr);
    @(negedge clk);
    bus.nbits    = nb;
    bus.osr_log2 = osr;
    bus.st_conv  = 1'b1;
    @(negedge clk);
    bus.st_conv  = 1'b0;
    bus.nbits    = 4'd1;
    bus.osr_log2 = 3'd0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (!bus.adc_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.adc_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_wait: no adc_done within %0d cycles", budget);
    end
  endtask

  int sw_nb[12]  = '{14, 14, 14, 14, 14, 14, 14, 4, 0, 15, 1, 1};
  int sw_ref[12] = '{'h0, 'h1, 'h3FFF, 'h2000, 'h1FFF, 'h2AAA, 'h1555, 'h3FFF, 'h5, 'h3001, 'h2001, 'h1FFF};
  int sw_exp[12] = '{'h0, 'h1, 'h3FFF, 'h2000, 'h1FFF, 'h2AAA, 'h1555, 'h3C00, 'h5, 'h3001, 'h2000, 'h0};
  int sw_lat[12] = '{46, 46, 46, 46, 46, 46, 46, 16, 46, 46, 7, 7};

  initial begin
    int cyc, s0, r0, d0, h0, l0, k;
    logic pv;
    bus.st_conv  = 1'b0;
    bus.nbits    = 4'd14;
    bus.osr_log2 = 3'd0;
    rst = 1'b0;
    #2;
    do_reset();

    // reset state
    check("rst_comp_req", 32'(bus.comp_req), 0);
    check("rst_sample", 32'(bus.sample), 0);
    check("rst_dac", 32'(bus.dac_value), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_done", 32'(bus.adc_done), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_terr", 32'(bus.timeout_err), 0);
    check("rst_state", 32'(bus.dbg_state), 0);

    // basic 12-bit conversion
    cmp_ref = 14'h268C;
    exp_q.push_back(18'h268C);
    r0 = req_rises; l0 = dac_low_hits; d0 = done_cnt;
    start_conv(4'd12, 3'd0);
    check("basic_busy_k1", 32'(bus.busy), 1);
    check("basic_sample_k1", 32'(bus.sample), 1);
    wait_done(200, cyc);
    check("basic_latency", 32'(cyc), 40);
    check("basic_dac", 32'(bus.dac_value), 32'h268C);
    @(negedge clk);
    check("basic_done_pulse", 32'(bus.adc_done), 0);
    check("basic_busy_fall", 32'(bus.busy), 0);
    check("basic_req_pulses", 32'(req_rises - r0), 12);
    check("basic_dac_low", 32'(dac_low_hits - l0), 0);
    check("basic_done_cnt", 32'(done_cnt - d0), 1);
    check("basic_dac_hold", 32'(bus.dac_value), 32'h268C);

    // sweep of boundary codes and resolutions
    for (int i = 0; i < 12; i++) begin
      cmp_ref = 14'(sw_ref[i]);
      exp_q.push_back(18'(sw_exp[i]));
      d0 = done_cnt;
      start_conv(4'(sw_nb[i]), 3'd0);
      wait_done(200, cyc);
      check("sweep_latency", 32'(cyc), 32'(sw_lat[i]));
      check("sweep_dac", 32'(bus.dac_value), 32'(sw_exp[i]));
      @(negedge clk);
      check("sweep_done_cnt", 32'(done_cnt - d0), 1);
    end

    // st_conv held high: back-to-back with one idle cycle
    cmp_ref = 14'h2AAA;
    d0 = done_cnt;
    repeat (3) exp_q.push_back(18'h2AAA);
    @(negedge clk);
    bus.nbits = 4'd14; bus.osr_log2 = 3'd0; bus.st_conv = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wait_done(100, cyc);
      check("hold_latency", 32'(cyc), 46);
      if (i == 2) begin
        bus.st_conv = 1'b0;
      end else begin
        @(negedge clk);
        check("hold_idle_gap", 32'(bus.busy), 0);
        @(negedge clk);
        check("hold_restart", 32'(bus.busy), 1);
      end
    end
    @(negedge clk);
    @(negedge clk);
    check("hold_done_cnt", 32'(done_cnt - d0), 3);
    check("hold_stopped", 32'(bus.busy), 0);

    // oversampling
    cmp_ref = 14'd100;
    exp_q.push_back(18'd400);
    s0 = smp_rises; d0 = done_cnt;
    start_conv(4'd14, 3'd2);
    wait_done(1000, cyc);
    check("osr2_latency", 32'(cyc), 181);
    @(negedge clk);
    check("osr2_samples", 32'(smp_rises - s0), 4);
    check("osr2_done_cnt", 32'(done_cnt - d0), 1);

    exp_q.push_back(18'd1600);
    s0 = smp_rises;
    start_conv(4'd14, 3'd7);
    wait_done(2000, cyc);
    check("osr7_latency", 32'(cyc), 721);
    @(negedge clk);
    check("osr7_samples", 32'(smp_rises - s0), 16);

    // delayed ack / release
    ack_dly = 5; rel_dly = 3;
    cmp_ref = 14'h1234;
    exp_q.push_back(18'h1234);
    start_conv(4'd14, 3'd0);
    wait_done(400, cyc);
    check("delay_latency", 32'(cyc), 130);
    @(negedge clk);
    ack_dly = 1; rel_dly = 1;

    // timeout: comparator never answers
    cmp_never = 1'b1;
    h0 = req_hi; d0 = done_cnt;
    start_conv(4'd14, 3'd0);
    cyc = 1;
    while (!bus.timeout_err && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("to_flag", 32'(bus.timeout_err), 1);
    check("to_cycle", 32'(cyc), 20);
    check("to_comp_req", 32'(bus.comp_req), 0);
    check("to_busy", 32'(bus.busy), 0);
    check("to_result_kept", 32'(bus.result), 32'h1234);
    @(negedge clk);
    check("to_req_cycles", 32'(req_hi - h0), 16);
    check("to_no_done", 32'(done_cnt - d0), 0);
    cmp_never = 1'b0;
    repeat (3) @(negedge clk);

    cmp_ref = 14'h0ABC;
    exp_q.push_back(18'h0ABC);
    start_conv(4'd14, 3'd0);
    check("to_cleared", 32'(bus.timeout_err), 0);
    wait_done(200, cyc);
    check("to_recover_latency", 32'(cyc), 46);
    @(negedge clk);

    // reset mid-conversion at bit index 8
    cmp_ref = 14'h3FFF;
    start_conv(4'd14, 3'd0);
    k = 0; cyc = 0; pv = bus.comp_req;
    while (k < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.comp_req && !pv) k++;
      pv = bus.comp_req;
    end
    check("mid_reach_idx8", 32'(k), 6);
    rst = 1'b1;
    #1;
    check("mid_rst_comp_req", 32'(bus.comp_req), 0);
    check("mid_rst_dac", 32'(bus.dac_value), 0);
    check("mid_rst_result", 32'(bus.result), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_state", 32'(bus.dbg_state), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // start ignored while busy
    exp_q.push_back(18'h3FFF);
    d0 = done_cnt;
    start_conv(4'd14, 3'd0);
    cyc = 1;
    while (!bus.adc_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.st_conv = (cyc % 5 == 0) && (cyc < 35);
    end
    bus.st_conv = 1'b0;
    check("busy_start_latency", 32'(cyc), 46);
    repeat (3) @(negedge clk);
    check("busy_start_done_cnt", 32'(done_cnt - d0), 1);
    check("busy_start_idle", 32'(bus.busy), 0);

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
